// File: rtl/rv32_types.sv
// Shared RV32 core types: memory request bundle and arbiter state.
// Imported by the memory arbiter, its interface and the winner picker.
package rv32_types;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef struct packed {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] data;
    } memory_request_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic req_valid(input memory_request_t r);
        return r.op != MEM_NOP;
    endfunction

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Downstream data-memory port: request out, ready/read data back.
// master = arbiter side, slave = memory side.
import rv32_types::*;

interface rv32_mem_arbiter_if;
    memory_request_t mem_req_o;
    logic            mem_ready_i;
    logic [31:0]     mem_rdata_i;

    modport master (
        output mem_req_o,
        input  mem_ready_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        output mem_ready_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/rv32_rr_pick2.sv
// Two-way winner selection: fixed priority to port 0 or
// round-robin on ties, alternating away from the last owner.
module rv32_rr_pick2 #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       win_o
);

    // A lone requester always wins; ties go by policy.
    always_comb begin
        win_o = 1'b0;
        if (valid_i[0] && valid_i[1]) begin
            win_o = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_i;
        end else begin
            win_o = valid_i[1];
        end
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares the data-memory port between the memory stage (port 0)
// and fetch/debug (port 1); one request in flight, with watchdog.
import rv32_types::*;

module rv32_mem_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  memory_request_t     req0_i,
    input  memory_request_t     req1_i,
    output logic [1:0]          done_o,
    output logic [31:0]         rdata_o,
    rv32_mem_arbiter_if.master  mem,
    output logic                grant_o,
    output logic                busy_o,
    output logic                timeout_err_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    arb_state_t      state;
    memory_request_t req_q;
    logic            last_grant;
    logic [CW-1:0]   cnt;
    logic [1:0]      valid;
    logic            win;
    logic            expire;

    assign valid  = {req_valid(req1_i), req_valid(req0_i)};
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    rv32_rr_pick2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .valid_i(valid),
        .last_i (last_grant),
        .win_o  (win)
    );

    // The captured request goes out as-is; its op is NOP when idle.
    assign mem.mem_req_o = req_q;
    assign busy_o        = (state == BUSY);

    // Same-cycle completion to the owner; a reset cycle never completes.
    always_comb begin
        done_o  = '0;
        rdata_o = '0;
        if (resetn && state == BUSY &&
            (mem.mem_ready_i || expire)) begin
            done_o[grant_o] = 1'b1;
            rdata_o = mem.mem_ready_i ? mem.mem_rdata_i : '0;
        end
    end

    // Arbitration FSM, request capture and watchdog.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            req_q         <= '{op: MEM_NOP, addr: '0, data: '0};
            grant_o       <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|valid) begin
                        state      <= BUSY;
                        req_q      <= win ? req1_i : req0_i;
                        grant_o    <= win;
                        last_grant <= win;
                        cnt        <= '0;
                    end
                end
                BUSY: begin
                    if (mem.mem_ready_i) begin
                        state    <= IDLE;
                        req_q.op <= MEM_NOP;
                    end else if (expire) begin
                        state         <= IDLE;
                        req_q.op      <= MEM_NOP;
                        timeout_err_o <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
